mul8u_err_monitor: RTL and testbench

- Streaming error-characterisation stage that sits directly downstream of an 8x8 unsigned multiplier under evaluation (exact or approximate).
- Accepts operand pairs plus the multiplier's 16-bit product and computes the exact product internally.
- Accumulates over a fixed-length run: sample count, error count (EP numerator), sum of absolute error (MAE numerator), and worst-case absolute error (WCE) with the operand pair that produced it.
- The FPGA characterisation harness reads the results when `done` is asserted.

---
 rtl/mul8u_err_pkg.sv | 18 +
 rtl/mul8u_abs_err.sv | 22 ++
 rtl/mul8u_err_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_mul8u_err_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul8u_err_pkg.sv
// Shared types and constants for the 8x8 multiplier error monitors.
// State encoding, drain length and default widths.
package mul8u_err_pkg;

  localparam int N_W_DEF   = 8;
  localparam int CNT_W_DEF = 32;
  localparam int SUM_W_DEF = 40;

  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/mul8u_abs_err.sv
// Exact product and absolute error against a product under test.
// Ports: a_i, b_i operands; o_i product under test; abs_err_o = |a*b - o|.
module mul8u_abs_err #(
  parameter int N_W = 8
) (
  input  logic [N_W-1:0]   a_i,
  input  logic [N_W-1:0]   b_i,
  input  logic [2*N_W-1:0] o_i,
  output logic [2*N_W-1:0] abs_err_o
);

  logic [2*N_W-1:0] exact;

  assign exact = {{N_W{1'b0}}, a_i} * {{N_W{1'b0}}, b_i};

  // Subtract the smaller from the larger; the result always fits 2*N_W.
  always_comb begin
    if (exact >= o_i) abs_err_o = exact - o_i;
    else              abs_err_o = o_i - exact;
  end

endmodule

// File: rtl/mul8u_err_monitor.sv
// Run-based error statistics (count, EP, MAE sum, WCE) for a multiplier.
// Ports: start/run_len control, in_* beat stream, busy/done, statistics.
module mul8u_err_monitor
  import mul8u_err_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   run_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_W-1:0]     in_a,
  input  logic [N_W-1:0]     in_b,
  input  logic [2*N_W-1:0]   in_o,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W-1:0]   sum_abs_err,
  output logic               sum_sat,
  output logic [2*N_W-1:0]   max_abs_err,
  output logic [N_W-1:0]     max_a,
  output logic [N_W-1:0]     max_b
);

  localparam int P_W = 2 * N_W;
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             clr;
  logic             fire;

  logic             s1_v_q;
  logic [N_W-1:0]   s1_a_q, s1_b_q;
  logic [P_W-1:0]   s1_o_q;
  logic             s2_v_q;
  logic [N_W-1:0]   s2_a_q, s2_b_q;
  logic [P_W-1:0]   s2_err_q;
  logic [P_W-1:0]   abs_err;

  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0]   sum_ext;
  logic             sat_q, sat_d;
  logic [P_W-1:0]   max_q, max_d;
  logic [N_W-1:0]   ma_q, ma_d;
  logic [N_W-1:0]   mb_q, mb_d;

  assign in_ready = (state_q == S_RUN) && (acc_q < len_q);
  assign fire     = in_valid && in_ready;
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    acc_d   = acc_q;
    len_d   = len_q;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          len_d   = run_len;
          acc_d   = '0;
          clr     = 1'b1;
        end
      end
      S_RUN: begin
        if (acc_q == len_q) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (fire) begin
          acc_d = acc_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else drain_d = drain_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      acc_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
    end
  end

  mul8u_abs_err #(.N_W(N_W)) u_abs (
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .o_i       (s1_o_q),
    .abs_err_o (abs_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_o_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s2_err_q <= '0;
    end else begin
      s1_v_q <= fire;
      if (fire) begin
        s1_a_q <= in_a;
        s1_b_q <= in_b;
        s1_o_q <= in_o;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_a_q   <= s1_a_q;
        s2_b_q   <= s1_b_q;
        s2_err_q <= abs_err;
      end
    end
  end

  // One spare carry bit detects accumulator overflow.
  assign sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(s2_err_q);

  always_comb begin
    smp_d = smp_q;
    err_d = err_q;
    sum_d = sum_q;
    sat_d = sat_q;
    max_d = max_q;
    ma_d  = ma_q;
    mb_d  = mb_q;
    if (clr) begin
      smp_d = '0;
      err_d = '0;
      sum_d = '0;
      sat_d = 1'b0;
      max_d = '0;
      ma_d  = '0;
      mb_d  = '0;
    end else if (s2_v_q) begin
      smp_d = smp_q + CNT_W'(1);
      err_d = err_q + CNT_W'(s2_err_q != '0);
      if (sum_ext[SUM_W]) begin
        sum_d = '1;
        sat_d = 1'b1;
      end else begin
        sum_d = sum_ext[SUM_W-1:0];
      end
      if (s2_err_q > max_q) begin
        max_d = s2_err_q;
        ma_d  = s2_a_q;
        mb_d  = s2_b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      err_q <= '0;
      sum_q <= '0;
      sat_q <= 1'b0;
      max_q <= '0;
      ma_q  <= '0;
      mb_q  <= '0;
    end else begin
      smp_q <= smp_d;
      err_q <= err_d;
      sum_q <= sum_d;
      sat_q <= sat_d;
      max_q <= max_d;
      ma_q  <= ma_d;
      mb_q  <= mb_d;
    end
  end

  assign sample_cnt  = smp_q;
  assign err_cnt     = err_q;
  assign sum_abs_err = sum_q;
  assign sum_sat     = sat_q;
  assign max_abs_err = max_q;
  assign max_a       = ma_q;
  assign max_b       = mb_q;

endmodule

// File: tb/tb_mul8u_err_monitor.sv
// Bench for mul8u_err_monitor: per-run expected statistics are queued
// by the stimulus and compared by a monitor each time done rises.
module tb_mul8u_err_monitor;

  localparam int N_W   = 8;
  localparam int CNT_W = 32;
  localparam int SUM_W = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] run_len;
  logic             in_valid;
  logic             in_ready;
  logic [N_W-1:0]   in_a, in_b;
  logic [2*N_W-1:0] in_o;
  logic             busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [SUM_W-1:0] sum_abs_err;
  logic             sum_sat;
  logic [2*N_W-1:0] max_abs_err;
  logic [N_W-1:0]   max_a, max_b;

  mul8u_err_monitor #(.N_W(N_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_len(run_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_abs_err(sum_abs_err), .sum_sat(sum_sat),
    .max_abs_err(max_abs_err), .max_a(max_a), .max_b(max_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint smp, err, sum, sat, mx, ma, mb;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic done_p = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input longint s, e, su, sa, m, a, b);
    exp_t x;
    x.smp = s; x.err = e; x.sum = su; x.sat = sa;
    x.mx = m; x.ma = a; x.mb = b;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n && done && !done_p) begin
      if (sb.size() == 0) begin
        chk("sb_empty_at_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sample_cnt", longint'(sample_cnt), e.smp);
        chk("err_cnt", longint'(err_cnt), e.err);
        chk("sum_abs_err", longint'(sum_abs_err), e.sum);
        chk("sum_sat", longint'(sum_sat), e.sat);
        chk("max_abs_err", longint'(max_abs_err), e.mx);
        chk("max_a", longint'(max_a), e.ma);
        chk("max_b", longint'(max_b), e.mb);
      end
    end
    done_p <= done;
  end

  task automatic do_start(input longint len);
    @(negedge clk);
    start = 1'b1;
    run_len = CNT_W'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input int a, b, o);
    int n;
    in_a = N_W'(a);
    in_b = N_W'(b);
    in_o = (2*N_W)'(o);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, longint'(in_ready), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_smp"}, longint'(sample_cnt), 0);
    chk({tag, "_sum"}, longint'(sum_abs_err), 0);
    chk({tag, "_max"}, longint'(max_abs_err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rdy;
    rst_n = 1'b0;
    start = 1'b0;
    run_len = '0;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_o = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_zero("reset");

    // exact stream
    push(4, 0, 0, 0, 0, 0, 0);
    do_start(4);
    send(3, 5, 15);
    send(255, 255, 65025);
    send(0, 200, 0);
    send(17, 1, 17);
    wait_done();

    // both error signs, ties keep first
    push(3, 3, 12, 0, 4, 2, 3);
    do_start(3);
    send(2, 3, 10);
    send(4, 4, 12);
    send(7, 1, 3);
    wait_done();

    // handshake and latency, valid held high throughout
    push(2, 0, 0, 0, 0, 0, 0);
    do_start(2);
    chk("busy_run", longint'(busy), 1);
    in_a = 8'd1; in_b = 8'd1; in_o = 16'd1;
    in_valid = 1'b1;
    rdy = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) rdy++;
      if (i == 2) chk("lat_smp_k1", longint'(sample_cnt), 0);
      if (i == 3) chk("lat_smp_k2", longint'(sample_cnt), 1);
      @(negedge clk);
    end
    chk("ready_cycles", rdy, 2);
    wait_done();
    repeat (3) @(negedge clk);
    chk("done_ignores_smp", longint'(sample_cnt), 2);
    chk("done_ready", longint'(in_ready), 0);
    in_valid = 1'b0;

    // zero-length run
    push(0, 0, 0, 0, 0, 0, 0);
    do_start(0);
    wait_done();

    // saturation
    do_start(17);
    for (int i = 0; i < 16; i++) send(255, 255, 0);
    repeat (3) @(negedge clk);
    chk("sum_16", longint'(sum_abs_err), 1040400);
    chk("sat_16", longint'(sum_sat), 0);
    push(17, 17, 1048575, 1, 65025, 255, 255);
    send(255, 255, 0);
    wait_done();

    // start during RUN is ignored
    push(3, 1, 9, 0, 9, 3, 3);
    do_start(3);
    send(2, 2, 4);
    do_start(1);
    send(3, 3, 0);
    send(1, 1, 1);
    wait_done();

    // restart from DONE clears everything
    push(1, 1, 5, 0, 5, 5, 5);
    do_start(1);
    chk("restart_smp", longint'(sample_cnt), 0);
    chk("restart_err", longint'(err_cnt), 0);
    chk("restart_sum", longint'(sum_abs_err), 0);
    chk("restart_max", longint'(max_abs_err), 0);
    chk("restart_ma", longint'(max_a), 0);
    send(5, 5, 20);
    wait_done();

    // reset with two beats in flight
    do_start(4);
    send(9, 9, 0);
    send(8, 8, 0);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero("post_rst");
    chk("post_rst_err", longint'(err_cnt), 0);
    chk("post_rst_ma", longint'(max_a), 0);
    chk("post_rst_mb", longint'(max_b), 0);
    chk("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
